mem_io_ctrl: RTL and testbench
==============================

# mem_io_ctrl

Responder end of the CPU's byte-wide memory bus: serves single-byte reads and writes to a 128 KiB RAM and to the memory-mapped I/O page at 0x30000. Sits between the CPU core and the UART/host link. It provides the one-cycle read latency, the `io_buffer_full` back-pressure and the program-stop sequence that the core's bus arbitration relies on. Owns the tx byte FIFO, the optional rx path, the cycle counter and the run/halt state.

## Interface
- `RAM_ADDR_WIDTH`, 17: RAM byte address bits (128 KiB).
- `TX_DEPTH_LOG2`, 3: tx FIFO depth = 2^TX_DEPTH_LOG2 bytes.
- `RAM_INIT_FILE`, "": hex image loaded at elaboration; empty means no load.

Ports (clock and reset first):
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset. Synchronous, active-high.
- `mem_a`  in  32  byte address from the CPU.
- `mem_wr`  in  1  1 = write, 0 = read.
- `mem_dout`  in  8  write data from the CPU.
- `mem_din`  out  8  read data to the CPU, valid the cycle after the request.
- `io_buffer_full`  out  1  tx FIFO has at most 1 free slot.
- `cpu_rdy`  out  1  drives the CPU's `rdy_in`.
- `tx_data`  out  8  uart tx byte.
- `tx_valid`  out  1  tx FIFO not empty.
- `tx_ready`  in  1  uart accepts `tx_data` this cycle.
- `rx_data`  in  8  host input byte.
- `rx_valid`  in  1  `rx_data` is present.
- `rx_ready`  out  1  rx byte consumed this cycle.
- `program_done`  out  1  halt complete and tx drained.
- `tx_overflow`  out  1  sticky: a tx push was dropped.

## Operation
- Decode: `mem_a[17:16]==2'b11` selects I/O; any other value selects RAM at `mem_a[RAM_ADDR_WIDTH-1:0]`. Requests are accepted only while `cpu_rdy`=1; otherwise they are ignored.
- RAM write: the byte is stored at the clock edge.
- RAM read: the byte is registered onto `mem_din` at the next edge.
- I/O write 0x30000: push `mem_dout` into the tx FIFO. 0x00 is ignored. If the FIFO is full, drop the byte and set `tx_overflow`.
- I/O write 0x30004: push 0x00, bypassing the ignore rule; the full rule still applies. State moves RUN -> DRAIN.
- I/O read 0x30000: if `rx_valid`, return `rx_data` and pulse `rx_ready` for one cycle; otherwise return 0x00.
- I/O read 0x30004..0x30007: return byte `mem_a[1:0]` of the cycle snapshot. A read of 0x30004 first copies the live counter into the snapshot, so a 4-byte read is coherent.
- Other I/O addresses: read returns 0x00; writes are ignored.
- Cycle counter: 32 bits, increments every cycle `cpu_rdy`=1, wraps 0xFFFFFFFF -> 0.
- State machine:
  - RUN: `cpu_rdy`=1.
  - DRAIN: `cpu_rdy`=0; go to DONE when the tx FIFO is empty.
  - DONE: `cpu_rdy`=0, `program_done`=1. Exits only on reset.
- tx FIFO:
  - Pop when `tx_valid && tx_ready`.
  - Simultaneous push and pop when full: the pop frees the slot, so the push succeeds.
  - Simultaneous push and pop when empty: the push is stored and `tx_valid` rises next cycle. There is no bypass.
  - Pointers wrap modulo depth.

## Timing
- Read latency is exactly 1 cycle. `mem_din` holds its value until the next read completes.
- `io_buffer_full` is combinational from the FIFO count: asserted when count ≥ 2^TX_DEPTH_LOG2 − 1. This covers the one write already in flight from the CPU.
- Reset values:
  - `mem_din`=0, `io_buffer_full`=0, `tx_valid`=0, `tx_data`=0, `rx_ready`=0, `program_done`=0, `tx_overflow`=0, `cpu_rdy`=1.
  - State=RUN; counter, snapshot and FIFO pointers are 0.
  - RAM contents are not cleared.
- Reset mid-drain: FIFO contents are discarded and the block returns to RUN on the next cycle.

## Configuration
- `MEM_IO_CTRL_RX_EN` defined: the rx path operates as described.
- `MEM_IO_CTRL_RX_EN` undefined:
  - 0x30000 reads return 0x00.
  - `rx_ready` is tied 0.
  - `rx_data` and `rx_valid` are ignored; the ports remain in the port list.

## Structure
- Package `mem_io_pkg` holds:
  - `IO_PAGE`=2'b11, `IO_PORT_ADDR`=0x30000, `IO_CLK_ADDR`=0x30004.
  - State enum `{ST_RUN, ST_DRAIN, ST_DONE}`.
- Sub-module `byte_fifo`: parameterised depth, push/pop/full/empty/count. Instantiated once for tx.

## Test plan
- Write 0xA5 to 0x00123, then read 0x00123 -> `mem_din`=0xA5 exactly one cycle after the read.
- Write 'H' and 'i' to 0x30000, with `tx_ready` held 0 then released -> `tx_data` 0x48 then 0x69. A write of 0x00 to 0x30000 is not pushed.
- Write 7 bytes with `TX_DEPTH_LOG2`=3 and `tx_ready`=0 -> `io_buffer_full`=1 after the 7th push. An 9th write attempt sets `tx_overflow`; the FIFO holds 8 bytes.
- Run 1000 cycles after reset, then read 0x30004..0x30007 -> bytes of the snapshot equal 1000 ± the read cycle offset, little-endian, and consistent across all four reads.
- Write 0x30004 with 2 bytes queued and `tx_ready`=1 -> `cpu_rdy` falls the next cycle. Bytes drain, then 0x00 is sent, then `program_done`=1.
- With `MEM_IO_CTRL_RX_EN` defined and `rx_valid`=1, `rx_data`=0x3C, read 0x30000 -> returns 0x3C with a 1-cycle `rx_ready` pulse. With `rx_valid`=0 -> returns 0x00.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared constants and state encoding for the CPU memory/IO responder.
package mem_io_pkg;

  localparam logic [1:0]  IO_PAGE      = 2'b11;
  localparam logic [17:0] IO_PORT_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic is_io_page(input logic [31:0] addr);
    return addr[17:16] == IO_PAGE;
  endfunction

endpackage

// File: rtl/mem_io_ctrl_if.sv
// Byte-wide CPU bus plus uart tx/rx and status lines seen by mem_io_ctrl.
interface mem_io_ctrl_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        cpu_rdy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_done;
  logic        tx_overflow;

  modport master (
    output mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full, cpu_rdy, tx_data, tx_valid,
           rx_ready, program_done, tx_overflow
  );

  modport slave (
    input  mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full, cpu_rdy, tx_data, tx_valid,
           rx_ready, program_done, tx_overflow
  );
endinterface

// File: rtl/mem_io_ctrl_byte_fifo.sv
// Power-of-two byte FIFO; a pop in the same cycle frees room for a push when full.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mem_io_ctrl.sv
// Responder for the CPU byte bus: 128 KiB RAM, I/O page at 0x30000, tx FIFO and halt sequencing.
// Optional rx path enabled by defining MEM_IO_CTRL_RX_EN.
//
// state    | meaning
// ST_RUN   | CPU running, bus requests accepted, cycle counter advancing
// ST_DRAIN | halt requested, CPU stalled until tx FIFO empties
// ST_DONE  | halted and drained; left only through reset
module mem_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int    RAM_ADDR_WIDTH = 17,
  parameter int    TX_DEPTH_LOG2  = 3,
  parameter string RAM_INIT_FILE  = ""
) (
  input logic          clk_in,
  input logic          rst_in,
  mem_io_ctrl_if.slave bus
);
  localparam logic [TX_DEPTH_LOG2:0] FULL_MARK =
    (TX_DEPTH_LOG2 + 1)'((1 << TX_DEPTH_LOG2) - 1);

  state_t state;
  state_t state_nx;
  logic   run;
  logic   cpu_rdy_c;
  logic   done_c;

  logic [7:0]                ram [2**RAM_ADDR_WIDTH];
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]                ram_q;
  logic [7:0]                io_q;
  logic                      src_io_q;
  logic [7:0]                io_byte;
  logic [7:0]                rx_byte;
  logic                      rx_take;

  logic        io_sel;
  logic [17:0] io_addr;
  logic        rd_en;
  logic        ram_we;
  logic        ram_rd;
  logic        port_wr;
  logic        halt_wr;
  logic        port_rd;
  logic        snap_load;

  logic [31:0] cycle_cnt;
  logic [31:0] snap;

  logic                     tx_push;
  logic                     tx_pop;
  logic [7:0]               tx_din;
  logic [7:0]               fifo_dout;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [TX_DEPTH_LOG2:0]   fifo_count;
  logic                     unused_addr_bits;

  assign run      = (state == ST_RUN);
  assign io_sel   = is_io_page(bus.mem_a);
  assign io_addr  = bus.mem_a[17:0];
  assign ram_addr = bus.mem_a[RAM_ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^bus.mem_a[31:18];

  assign rd_en     = run && !bus.mem_wr;
  assign ram_we    = run && bus.mem_wr && !io_sel;
  assign ram_rd    = rd_en && !io_sel;
  assign port_wr   = run && bus.mem_wr && io_sel && (io_addr == IO_PORT_ADDR);
  assign halt_wr   = run && bus.mem_wr && io_sel && (io_addr == IO_CLK_ADDR);
  assign port_rd   = rd_en && io_sel && (io_addr == IO_PORT_ADDR);
  assign snap_load = rd_en && io_sel && (io_addr == IO_CLK_ADDR);

  // The halt marker is a literal 0x00 that must reach the host, so it skips the null filter.
  assign tx_push = (port_wr && (bus.mem_dout != 8'h00)) || halt_wr;
  assign tx_din  = halt_wr ? 8'h00 : bus.mem_dout;
  assign tx_pop  = bus.tx_valid && bus.tx_ready;

`ifdef MEM_IO_CTRL_RX_EN
  assign rx_take = port_rd && bus.rx_valid && !rst_in;
  assign rx_byte = bus.rx_valid ? bus.rx_data : 8'h00;
`else
  logic unused_rx;
  assign unused_rx = ^{bus.rx_data, bus.rx_valid, port_rd};
  assign rx_take   = 1'b0;
  assign rx_byte   = 8'h00;
`endif

  assign bus.rx_ready = rx_take;

  always_comb begin
    io_byte = 8'h00;
    if (io_addr == IO_PORT_ADDR) begin
      io_byte = rx_byte;
    end else if (io_addr[17:2] == IO_CLK_ADDR[17:2]) begin
      // Byte 0 reads the live counter, since that same read loads the snapshot.
      case (io_addr[1:0])
        2'b00:   io_byte = cycle_cnt[7:0];
        2'b01:   io_byte = snap[15:8];
        2'b10:   io_byte = snap[23:16];
        default: io_byte = snap[31:24];
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= bus.mem_dout;
    if (ram_rd) ram_q <= ram[ram_addr];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_io_q <= 1'b1;
      io_q     <= 8'h00;
    end else if (rd_en) begin
      src_io_q <= io_sel;
      if (io_sel) io_q <= io_byte;
    end
  end

  assign bus.mem_din = src_io_q ? io_q : ram_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_cnt <= '0;
      snap      <= '0;
    end else begin
      if (run)       cycle_cnt <= cycle_cnt + 32'd1;
      if (snap_load) snap      <= cycle_cnt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.tx_overflow <= 1'b0;
    end else if (tx_push && fifo_full && !tx_pop) begin
      bus.tx_overflow <= 1'b1;
    end
  end

  byte_fifo #(
    .DEPTH_LOG2(TX_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.tx_valid       = !fifo_empty;
  assign bus.tx_data        = fifo_empty ? 8'h00 : fifo_dout;
  assign bus.io_buffer_full = (fifo_count >= FULL_MARK);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cpu_rdy_c = 1'b0;
    done_c    = 1'b0;
    case (state)
      ST_RUN: begin
        cpu_rdy_c = 1'b1;
        if (halt_wr) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done_c = 1'b1;
      end
      default: state_nx = ST_RUN;
    endcase
  end

  assign bus.cpu_rdy      = cpu_rdy_c;
  assign bus.program_done = done_c;
endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl: RAM vector table plus tx, counter, rx and halt sequences.
module tb_mem_io_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_io_ctrl_if bus();

  mem_io_ctrl dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
    logic        chk;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int unsigned exp_cnt = 0;
  logic [7:0]  txq[$];
  logic [7:0]  got[$];
  vec_t        vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (rst) exp_cnt = 0;
    else     exp_cnt++;
  endtask

  task automatic idle;
    bus.mem_a    = 32'h0;
    bus.mem_wr   = 1'b0;
    bus.mem_dout = 8'h00;
  endtask

  task automatic bus_op(input logic [31:0] a, input logic wr, input logic [7:0] d);
    bus.mem_a    = a;
    bus.mem_wr   = wr;
    bus.mem_dout = d;
    tick();
    idle();
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    txq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    logic [31:0] act;
    int          n;

    idle();
    bus.tx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    do_reset();
    check("rst_mem_din",      bus.mem_din,        0);
    check("rst_buf_full",     bus.io_buffer_full, 0);
    check("rst_tx_valid",     bus.tx_valid,       0);
    check("rst_tx_data",      bus.tx_data,        0);
    check("rst_rx_ready",     bus.rx_ready,       0);
    check("rst_program_done", bus.program_done,   0);
    check("rst_tx_overflow",  bus.tx_overflow,    0);
    check("rst_cpu_rdy",      bus.cpu_rdy,        1);

    // RAM read/write vectors; mem_din is checked one edge after each request
    vecs.push_back('{32'h0000_0123, 1'b1, 8'hA5, 1'b0, 8'h00, "w_123"});
    vecs.push_back('{32'h0000_0123, 1'b0, 8'h00, 1'b1, 8'hA5, "ram_rd_123"});
    vecs.push_back('{32'h0000_0050, 1'b1, 8'h77, 1'b1, 8'hA5, "din_hold_on_write"});
    vecs.push_back('{32'h0001_FFFF, 1'b1, 8'h3C, 1'b0, 8'h00, "w_top"});
    vecs.push_back('{32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'h3C, "ram_rd_top"});
    vecs.push_back('{32'h0000_0000, 1'b1, 8'h11, 1'b0, 8'h00, "w_zero"});
    vecs.push_back('{32'h0000_0000, 1'b0, 8'h00, 1'b1, 8'h11, "ram_rd_zero"});
    vecs.push_back('{32'h0002_0123, 1'b1, 8'h5A, 1'b0, 8'h00, "w_page2_alias"});
    vecs.push_back('{32'h0000_0123, 1'b0, 8'h00, 1'b1, 8'h5A, "alias_page2"});
    vecs.push_back('{32'h4000_0123, 1'b0, 8'h00, 1'b1, 8'h5A, "alias_upper_bits"});
    vecs.push_back('{32'h0000_0050, 1'b0, 8'h00, 1'b1, 8'h77, "ram_rd_50"});
    vecs.push_back('{32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00, "io_unmapped_rd"});
    vecs.push_back('{32'h0003_0010, 1'b1, 8'hEE, 1'b0, 8'h00, "io_unmapped_wr"});
    vecs.push_back('{32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'h3C, "ram_rd_top_again"});
    for (int i = 0; i < vecs.size(); i++) begin
      bus_op(vecs[i].a, vecs[i].wr, vecs[i].d);
      if (vecs[i].chk) check(vecs[i].name, bus.mem_din, vecs[i].exp);
    end
    check("unmapped_wr_no_push", bus.tx_valid, 0);

    // tx: 'H', a filtered 0x00, 'i' with the uart stalled
    bus.tx_ready = 1'b0;
    bus_op(32'h30000, 1'b1, 8'h48);
    check("tx_valid_rise", bus.tx_valid, 1);
    bus_op(32'h30000, 1'b1, 8'h00);
    bus_op(32'h30000, 1'b1, 8'h69);
    check("tx_head_H", bus.tx_data, 8'h48);
    check("tx_not_full_2", bus.io_buffer_full, 0);
    bus.tx_ready = 1'b1;
    tick();
    check("tx_head_i", bus.tx_data, 8'h69);
    tick();
    check("tx_zero_not_pushed", bus.tx_valid, 0);

    // push into an empty FIFO while the uart is ready: no bypass
    bus.mem_a = 32'h30000; bus.mem_wr = 1'b1; bus.mem_dout = 8'h77;
    #1;
    check("no_bypass_before", bus.tx_valid, 0);
    tick();
    idle();
    check("no_bypass_after", bus.tx_valid, 1);
    check("no_bypass_data", bus.tx_data, 8'h77);
    tick();
    check("no_bypass_drained", bus.tx_valid, 0);
    bus.tx_ready = 1'b0;

    // fill to depth, then push+pop at full, then a dropped push
    for (int i = 1; i <= 8; i++) begin
      bus_op(32'h30000, 1'b1, 8'(i));
      txq.push_back(8'(i));
      check($sformatf("buf_full_after_%0d", i), bus.io_buffer_full, (i >= 7) ? 1 : 0);
    end
    check("no_overflow_at_8", bus.tx_overflow, 0);
    bus.tx_ready = 1'b1;
    bus_op(32'h30000, 1'b1, 8'h09);
    void'(txq.pop_front());
    txq.push_back(8'h09);
    bus.tx_ready = 1'b0;
    check("push_pop_full_no_ovf", bus.tx_overflow, 0);
    check("push_pop_full_still_full", bus.io_buffer_full, 1);
    bus_op(32'h30000, 1'b1, 8'h0A);
    check("overflow_sticky_set", bus.tx_overflow, 1);
    bus.tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_byte_%0d", k), bus.tx_data, txq.pop_front());
      tick();
    end
    check("drain_empty", bus.tx_valid, 0);
    bus.tx_ready = 1'b0;

    // cycle counter snapshot
    do_reset();
    repeat (1000) tick();
    e = exp_cnt;
    bus_op(32'h30004, 1'b0, 8'h00);
    check("clk_b0", bus.mem_din, e[7:0]);
    bus_op(32'h30005, 1'b0, 8'h00);
    check("clk_b1", bus.mem_din, e[15:8]);
    bus_op(32'h30006, 1'b0, 8'h00);
    check("clk_b2", bus.mem_din, e[23:16]);
    bus_op(32'h30007, 1'b0, 8'h00);
    check("clk_b3", bus.mem_din, e[31:24]);
    repeat (20) tick();
    bus_op(32'h30005, 1'b0, 8'h00);
    check("clk_snap_hold", bus.mem_din, e[15:8]);

    // rx port
    bus_op(32'h0, 1'b0, 8'h00);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h3C;
    bus.mem_a    = 32'h30000;
    bus.mem_wr   = 1'b0;
    #1;
`ifdef MEM_IO_CTRL_RX_EN
    check("rx_ready_pulse", bus.rx_ready, 1);
`else
    check("rx_ready_tied", bus.rx_ready, 0);
`endif
    tick();
    idle();
`ifdef MEM_IO_CTRL_RX_EN
    check("rx_read_data", bus.mem_din, 8'h3C);
`else
    check("rx_read_disabled", bus.mem_din, 8'h00);
`endif
    check("rx_ready_one_cycle", bus.rx_ready, 0);
    bus.rx_valid = 1'b0;
    bus_op(32'h0, 1'b0, 8'h00);
    check("ram0_before_rx_empty", bus.mem_din, 8'h11);
    bus.mem_a = 32'h30000;
    #1;
    check("rx_ready_no_valid", bus.rx_ready, 0);
    tick();
    idle();
    check("rx_empty_reads_zero", bus.mem_din, 8'h00);

    // halt with two bytes queued
    bus_op(32'h30000, 1'b1, 8'hAA);
    bus_op(32'h30000, 1'b1, 8'hBB);
    got.delete();
    bus.tx_ready = 1'b1;
    bus.mem_a = 32'h30004; bus.mem_wr = 1'b1; bus.mem_dout = 8'h55;
    #1;
    check("halt_cpu_rdy_before", bus.cpu_rdy, 1);
    if (bus.tx_valid) got.push_back(bus.tx_data);
    tick();
    idle();
    check("halt_cpu_rdy_falls", bus.cpu_rdy, 0);
    n = 0;
    while (!bus.program_done && n < 20) begin
      if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
      tick();
      n++;
    end
    check("done_reached", bus.program_done, 1);
    check("done_latency", n, 3);
    check("done_tx_empty", bus.tx_valid, 0);
    check("halt_byte_count", got.size(), 3);
    for (int k = 0; k < 3; k++) begin
      act = (k < got.size()) ? {24'h0, got[k]} : 32'hDEAD;
      check($sformatf("halt_seq_%0d", k), act, (k == 0) ? 8'hAA : (k == 1) ? 8'hBB : 8'h00);
    end

    // DONE holds and ignores bus requests
    bus.mem_a = 32'h0000_0123; bus.mem_wr = 1'b1; bus.mem_dout = 8'hFF;
    repeat (5) tick();
    idle();
    check("done_holds", bus.program_done, 1);
    check("done_cpu_stalled", bus.cpu_rdy, 0);

    do_reset();
    check("post_done_rst_done", bus.program_done, 0);
    bus_op(32'h0000_0123, 1'b0, 8'h00);
    check("ram_kept_ignored_wr", bus.mem_din, 8'h5A);

    // reset while draining with the uart stalled
    bus.tx_ready = 1'b0;
    bus_op(32'h30000, 1'b1, 8'hC1);
    bus_op(32'h30004, 1'b1, 8'h00);
    repeat (3) tick();
    check("drain_stuck_done", bus.program_done, 0);
    check("drain_stuck_rdy", bus.cpu_rdy, 0);
    check("drain_stuck_valid", bus.tx_valid, 1);
    rst = 1'b1;
    tick();
    check("mid_drain_rst_rdy", bus.cpu_rdy, 1);
    check("mid_drain_rst_fifo", bus.tx_valid, 0);
    check("mid_drain_rst_done", bus.program_done, 0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
